capture_buffer: RTL and testbench

Parametrised sample capture buffer for the logic analyzer: stores a continuous stream of `SDW`-bit samples in a `DEPTH`-entry circular RAM while armed, freezes after a programmable number of post-trigger samples, then streams the newest `cfg_read_cnt` samples back oldest-first on an AXI-stream-style read port with per-group `tkeep`. It sits between `core` and `ctrl`, replacing the fixed-width SRAM interface. It adds configurable depth, channel-group masking, underfill handling and abort.

---
 rtl/capture_pkg.sv | 13 +
 rtl/capture_ram.sv | 33 +++
 rtl/capture_buffer.sv | 268 ++++++++++++++++++++++++++
 tb/tb_capture_buffer.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
// Shared types and defaults for the logic-analyzer sample capture buffer.
package capture_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        READ  = 2'd3
    } capture_state_t;

    localparam int CAPTURE_GW_DEFAULT = 8;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample RAM: synchronous write port, registered read port.
module capture_ram #(
    parameter int SDW   = 32,
    parameter int DEPTH = 4096,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           wr_en,
    input  logic [AW-1:0]  wr_addr,
    input  logic [SDW-1:0] wr_data,
    input  logic           rd_en,
    input  logic [AW-1:0]  rd_addr,
    output logic [SDW-1:0] rd_data
);

    logic [SDW-1:0] mem [DEPTH];
    logic [SDW-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/capture_buffer.sv
// Circular sample capture buffer with post-trigger delay and AXI-stream readout.
// Optional test-pattern source enabled by CAPTURE_BUFFER_TEST_PATTERN_EN.
module capture_buffer
    import capture_pkg::*;
#(
    parameter int SDW   = 32,
    parameter int GW    = CAPTURE_GW_DEFAULT,
    parameter int DEPTH = 4096,
    localparam int AW   = $clog2(DEPTH),
    localparam int NG   = SDW / GW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_arm,
    input  logic           cmd_abort,
    input  logic [NG-1:0]  cfg_groups,
    input  logic [AW:0]    cfg_delay_cnt,
    input  logic [AW:0]    cfg_read_cnt,
    input  logic           cfg_test,
    input  logic           sti_tvalid,
    input  logic [SDW-1:0] sti_tdata,
    input  logic           sti_trigger,
    output logic           mrd_tvalid,
    input  logic           mrd_tready,
    output logic [SDW-1:0] mrd_tdata,
    output logic [NG-1:0]  mrd_tkeep,
    output logic           mrd_tlast,
    output logic           armed,
    output logic           triggered,
    output logic           busy
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    function automatic logic [AW:0] sat_inc(input logic [AW:0] v);
        return (v == DEPTH_W) ? v : v + 1'b1;
    endfunction

    function automatic logic [AW:0] read_len(input logic [AW:0] req, input logic [AW:0] avail);
        logic [AW:0] want;
        want = (req == '0) ? DEPTH_W : req;
        return (want < avail) ? want : avail;
    endfunction

    capture_state_t state_q, state_d;
    logic [AW-1:0]  wp_q, wp_d;
    logic [AW:0]    fill_q, fill_d;
    logic [AW:0]    post_q, post_d;
    logic           trig_q, trig_d;
    logic [AW-1:0]  rp_q, rp_d;
    logic [AW:0]    rem_q, rem_d;
    logic [NG-1:0]  keep_q, keep_d;
    logic [AW:0]    rd_n;
    logic           wr_en, arm_go, read_go;
    logic [SDW-1:0] wr_data;

    logic           rd_issue;
    logic           rd_vld_p1_q, rd_vld_p1_d;
    logic           rd_last_p1_q, rd_last_p1_d;
    logic [SDW-1:0] ram_rdata;

    logic [SDW-1:0] fd_q [2];
    logic [SDW-1:0] fd_d [2];
    logic [1:0]     fl_q, fl_d;
    logic           wr_ptr_q, wr_ptr_d;
    logic           rd_ptr_q, rd_ptr_d;
    logic [1:0]     cnt_q, cnt_d;
    logic           pop, head_last;
    logic [2:0]     occ_after;

    assign pop       = (cnt_q != 2'd0) && mrd_tready;
    assign head_last = fl_q[rd_ptr_q];

    // Credit check: skid entries plus the in-flight RAM read must leave room for one more.
    assign occ_after = {1'b0, cnt_q} + {2'b0, rd_vld_p1_q} - {2'b0, pop};
    assign rd_issue  = (state_q == READ) && (rem_q != '0) && (occ_after < 3'd2) && !cmd_abort;

    always_comb begin
        state_d = state_q;
        wp_d    = wp_q;
        fill_d  = fill_q;
        post_d  = post_q;
        trig_d  = trig_q;
        rp_d    = rp_q;
        rem_d   = rem_q;
        keep_d  = keep_q;
        wr_en   = 1'b0;
        arm_go  = 1'b0;
        read_go = 1'b0;
        rd_n    = '0;
        if (cmd_abort) begin
            state_d = IDLE;
            trig_d  = 1'b0;
            rem_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cmd_arm) begin
                        arm_go  = 1'b1;
                        state_d = ARMED;
                        wp_d    = '0;
                        fill_d  = '0;
                        post_d  = '0;
                    end
                end
                ARMED: begin
                    if (sti_tvalid) begin
                        wr_en  = 1'b1;
                        wp_d   = wp_q + 1'b1;
                        fill_d = sat_inc(fill_q);
                        if (sti_trigger) begin
                            trig_d = 1'b1;
                            if (cfg_delay_cnt == '0) begin
                                state_d = READ;
                                read_go = 1'b1;
                            end else begin
                                post_d  = cfg_delay_cnt;
                                state_d = POST;
                            end
                        end
                    end
                end
                POST: begin
                    if (sti_tvalid) begin
                        wr_en  = 1'b1;
                        wp_d   = wp_q + 1'b1;
                        fill_d = sat_inc(fill_q);
                        post_d = post_q - 1'b1;
                        if (post_q == (AW+1)'(1)) begin
                            state_d = READ;
                            read_go = 1'b1;
                        end
                    end
                end
                READ: begin
                    if (rd_issue) begin
                        rp_d  = rp_q + 1'b1;
                        rem_d = rem_q - 1'b1;
                    end
                    if (pop && head_last) begin
                        state_d = IDLE;
                        trig_d  = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
            // The newest n samples end just below the post-write pointer.
            if (read_go) begin
                rd_n   = read_len(cfg_read_cnt, fill_d);
                rem_d  = rd_n;
                rp_d   = wp_d - rd_n[AW-1:0];
                keep_d = cfg_groups;
            end
        end
    end

`ifdef CAPTURE_BUFFER_TEST_PATTERN_EN
    logic [SDW-1:0] tp_cnt_q, tp_cnt_d;

    always_comb begin
        tp_cnt_d = tp_cnt_q;
        if (arm_go) begin
            tp_cnt_d = '0;
        end else if (wr_en) begin
            tp_cnt_d = tp_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tp_cnt_q <= '0;
        end else begin
            tp_cnt_q <= tp_cnt_d;
        end
    end

    assign wr_data = cfg_test ? tp_cnt_q : sti_tdata;
`else
    logic unused_cfg_test;
    assign unused_cfg_test = cfg_test;
    assign wr_data = sti_tdata;
`endif

    // RAM read stage (p0 -> p1)
    assign rd_vld_p1_d  = rd_issue;
    assign rd_last_p1_d = (rem_q == (AW+1)'(1));

    capture_ram #(
        .SDW   (SDW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wp_q),
        .wr_data (wr_data),
        .rd_en   (rd_issue),
        .rd_addr (rp_q),
        .rd_data (ram_rdata)
    );

    // Output skid stage (p1 -> p2)
    always_comb begin
        fd_d     = fd_q;
        fl_d     = fl_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q + {1'b0, rd_vld_p1_q} - {1'b0, pop};
        if (rd_vld_p1_q) begin
            fd_d[wr_ptr_q] = ram_rdata;
            fl_d[wr_ptr_q] = rd_last_p1_q;
            wr_ptr_d       = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (cmd_abort) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            cnt_d    = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            wp_q         <= '0;
            fill_q       <= '0;
            post_q       <= '0;
            trig_q       <= 1'b0;
            rp_q         <= '0;
            rem_q        <= '0;
            keep_q       <= '0;
            rd_vld_p1_q  <= 1'b0;
            rd_last_p1_q <= 1'b0;
            fd_q[0]      <= '0;
            fd_q[1]      <= '0;
            fl_q         <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            cnt_q        <= 2'd0;
        end else begin
            state_q      <= state_d;
            wp_q         <= wp_d;
            fill_q       <= fill_d;
            post_q       <= post_d;
            trig_q       <= trig_d;
            rp_q         <= rp_d;
            rem_q        <= rem_d;
            keep_q       <= keep_d;
            rd_vld_p1_q  <= rd_vld_p1_d;
            rd_last_p1_q <= rd_last_p1_d;
            fd_q         <= fd_d;
            fl_q         <= fl_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
        end
    end

    assign mrd_tvalid = (cnt_q != 2'd0);
    assign mrd_tdata  = fd_q[rd_ptr_q];
    assign mrd_tlast  = mrd_tvalid && head_last;
    assign mrd_tkeep  = keep_q;
    assign armed      = (state_q == ARMED) || (state_q == POST);
    assign triggered  = trig_q;
    assign busy       = (state_q == READ);

endmodule

// File: tb/tb_capture_buffer.sv
// Scoreboard bench for capture_buffer (DEPTH=16): queue-based reference model, decoupled monitor.
module tb_capture_buffer;

    localparam int SDW   = 32;
    localparam int GW    = 8;
    localparam int NG    = SDW / GW;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           cmd_arm = 1'b0;
    logic           cmd_abort = 1'b0;
    logic [NG-1:0]  cfg_groups = '0;
    logic [AW:0]    cfg_delay_cnt = '0;
    logic [AW:0]    cfg_read_cnt = '0;
    logic           cfg_test = 1'b0;
    logic           sti_tvalid = 1'b0;
    logic [SDW-1:0] sti_tdata = '0;
    logic           sti_trigger = 1'b0;
    logic           mrd_tvalid;
    logic           mrd_tready;
    logic [SDW-1:0] mrd_tdata;
    logic [NG-1:0]  mrd_tkeep;
    logic           mrd_tlast;
    logic           armed;
    logic           triggered;
    logic           busy;

    always #5 clk = ~clk;

    capture_buffer #(
        .SDW   (SDW),
        .GW    (GW),
        .DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_arm       (cmd_arm),
        .cmd_abort     (cmd_abort),
        .cfg_groups    (cfg_groups),
        .cfg_delay_cnt (cfg_delay_cnt),
        .cfg_read_cnt  (cfg_read_cnt),
        .cfg_test      (cfg_test),
        .sti_tvalid    (sti_tvalid),
        .sti_tdata     (sti_tdata),
        .sti_trigger   (sti_trigger),
        .mrd_tvalid    (mrd_tvalid),
        .mrd_tready    (mrd_tready),
        .mrd_tdata     (mrd_tdata),
        .mrd_tkeep     (mrd_tkeep),
        .mrd_tlast     (mrd_tlast),
        .armed         (armed),
        .triggered     (triggered),
        .busy          (busy)
    );

    typedef struct {
        logic [SDW-1:0] d;
        logic           l;
    } beat_t;

    beat_t          exp_q[$];
    logic [NG-1:0]  exp_keep = '0;
    int             checks = 0;
    int             errors = 0;
    int             acc_cnt = 0;
    int             rdy_mode = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        mrd_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: mrd_tready = 1'b1;
                1: mrd_tready = ~mrd_tready;
                2: mrd_tready = 1'($urandom % 2);
                default: ;
            endcase
        end
    end

    // Monitor: pops expected beats on every handshake and checks stall stability.
    initial begin
        bit             prev_stall = 0;
        bit             prev_abort = 0;
        logic [SDW-1:0] prev_data = '0;
        logic           prev_last = 0;
        logic [NG-1:0]  prev_keep = '0;
        beat_t          e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_stall = 0;
                continue;
            end
            if (prev_stall && !prev_abort) begin
                chk("stall_valid_held", mrd_tvalid, 1);
                chk("stall_data_held", mrd_tdata, prev_data);
                chk("stall_last_held", mrd_tlast, prev_last);
                chk("stall_keep_held", mrd_tkeep, prev_keep);
            end
            if (mrd_tvalid && mrd_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", mrd_tdata, 64'hDEAD_BEEF_DEAD_BEEF);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", mrd_tdata, e.d);
                    chk("beat_last", mrd_tlast, e.l);
                    chk("beat_keep", mrd_tkeep, exp_keep);
                end
                acc_cnt++;
            end
            prev_stall = mrd_tvalid && !mrd_tready;
            prev_abort = cmd_abort;
            prev_data  = mrd_tdata;
            prev_last  = mrd_tlast;
            prev_keep  = mrd_tkeep;
        end
    end

    // Drives one capture; the expected read-out is the newest min(req, stored, DEPTH) samples.
    task automatic do_capture(input int trig_idx, input int delay, input int rc,
                              input logic [NG-1:0] grp, input bit gaps, input bit rnd_data,
                              input bit testpat, input int nextra);
        int             nstore;
        int             n;
        int             f;
        bit             tp_on;
        logic [SDW-1:0] vals[$];
        logic [SDW-1:0] stored[$];
        nstore = trig_idx + delay + 1;
`ifdef CAPTURE_BUFFER_TEST_PATTERN_EN
        tp_on = testpat;
`else
        tp_on = 0;
`endif
        cfg_delay_cnt = (AW+1)'(delay);
        cfg_read_cnt  = (AW+1)'(rc);
        cfg_groups    = grp;
        cfg_test      = testpat;
        exp_keep      = grp;
        for (int i = 0; i < nstore + nextra; i++) begin
            vals.push_back(rnd_data ? SDW'($urandom) : SDW'(i));
        end
        for (int i = 0; i < nstore; i++) begin
            stored.push_back(tp_on ? SDW'(i) : vals[i]);
        end
        n = (rc == 0) ? DEPTH : rc;
        f = (nstore > DEPTH) ? DEPTH : nstore;
        if (f < n) n = f;
        for (int i = nstore - n; i < nstore; i++) begin
            exp_q.push_back(beat_t'{stored[i], (i == nstore - 1)});
        end
        acc_cnt = 0;
        cmd_arm = 1'b1;
        step();
        cmd_arm = 1'b0;
        chk("armed_after_arm", armed, 1);
        chk("triggered_clear_after_arm", triggered, 0);
        for (int i = 0; i < nstore + nextra; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    sti_tvalid  = 1'b0;
                    sti_trigger = 1'($urandom % 2);
                    sti_tdata   = SDW'($urandom);
                    step();
                end
            end
            sti_tvalid  = 1'b1;
            sti_tdata   = vals[i];
            sti_trigger = (i == trig_idx) || (i > trig_idx && ($urandom % 2) == 1);
            step();
            if (i == trig_idx) begin
                chk("triggered_set", triggered, 1);
                chk("state_after_trigger", (delay == 0) ? busy : armed, 1);
            end
            if (i == nstore - 1) begin
                chk("busy_on_read_entry", busy, 1);
            end
        end
        sti_tvalid  = 1'b0;
        sti_trigger = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (exp_q.size() != 0) begin
            chk("read_timeout_left", exp_q.size(), 0);
            exp_q.delete();
        end
        step();
        chk("idle_busy", busy, 0);
        chk("idle_armed", armed, 0);
        chk("idle_triggered", triggered, 0);
        chk("idle_tvalid", mrd_tvalid, 0);
        repeat (2) step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        repeat (3) @(negedge clk);
        chk("rst_tvalid", mrd_tvalid, 0);
        chk("rst_tdata", mrd_tdata, 0);
        chk("rst_tkeep", mrd_tkeep, 0);
        chk("rst_tlast", mrd_tlast, 0);
        chk("rst_armed", armed, 0);
        chk("rst_triggered", triggered, 0);
        chk("rst_busy", busy, 0);
        step();
        rst = 1'b1;
        step();

        // Post-trigger delay, values 17..24 expected
        do_capture(20, 4, 8, 4'b1011, 0, 0, 0, 3);
        wait_done();

        // Underfill: only 5 samples stored
        do_capture(2, 2, 16, 4'hF, 0, 0, 0, 2);
        wait_done();

        // Full wrap with read_cnt=0
        do_capture(39, 0, 0, 4'b0101, 0, 0, 0, 2);
        wait_done();

        // Back-pressure toggling every cycle
        rdy_mode = 1;
        do_capture(12, 3, 10, 4'b1110, 1, 1, 0, 2);
        wait_done();

        // Abort during the third beat
        rdy_mode = 3;
        mrd_tready = 1'b1;
        do_capture(20, 4, 8, 4'b0110, 0, 0, 0, 0);
        k = 0;
        while (acc_cnt < 2 && k < 100) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("abort_two_beats_taken", acc_cnt, 2);
        step();
        mrd_tready = 1'b0;
        cmd_abort  = 1'b1;
        @(negedge clk);
        chk("abort_beat3_valid", mrd_tvalid, 1);
        chk("abort_beat3_no_last", mrd_tlast, 0);
        step();
        cmd_abort = 1'b0;
        @(negedge clk);
        chk("abort_tvalid_low", mrd_tvalid, 0);
        chk("abort_tlast_low", mrd_tlast, 0);
        chk("abort_busy_low", busy, 0);
        chk("abort_triggered_low", triggered, 0);
        exp_q.delete();
        mrd_tready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("abort_quiet", mrd_tvalid, 0);
        end
        rdy_mode = 0;
        step();

        // Normal capture after abort
        do_capture(9, 1, 6, 4'b0011, 1, 1, 0, 1);
        wait_done();

        // Test pattern request (counter only when the feature is built in)
        do_capture(5, 3, 4, 4'hF, 1, 1, 1, 2);
        wait_done();
        cfg_test = 1'b0;

        // Randomised captures
        for (int it = 0; it < 6; it++) begin
            rdy_mode = int'($urandom_range(0, 2));
            do_capture(int'($urandom_range(0, 25)), int'($urandom_range(0, 6)),
                       int'($urandom_range(0, 16)), NG'($urandom), 1, 1, 0,
                       int'($urandom_range(0, 3)));
            wait_done();
        end
        rdy_mode = 0;
        step();

        // Reset asserted mid-POST
        cfg_delay_cnt = 5'd10;
        cfg_read_cnt  = 5'd4;
        cfg_groups    = 4'b1001;
        cmd_arm = 1'b1;
        step();
        cmd_arm = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sti_tvalid  = 1'b1;
            sti_tdata   = SDW'($urandom);
            sti_trigger = (i == 1);
            step();
        end
        chk("post_state_armed", armed, 1);
        chk("post_state_triggered", triggered, 1);
        #3;
        rst = 1'b0;
        #1;
        chk("midrst_armed", armed, 0);
        chk("midrst_triggered", triggered, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_tvalid", mrd_tvalid, 0);
        chk("midrst_tdata", mrd_tdata, 0);
        chk("midrst_tkeep", mrd_tkeep, 0);
        chk("midrst_tlast", mrd_tlast, 0);
        step();
        rst = 1'b1;
        sti_tvalid  = 1'b0;
        sti_trigger = 1'b0;
        repeat (3) step();
        chk("after_rst_armed", armed, 0);
        chk("after_rst_busy", busy, 0);
        chk("after_rst_tvalid", mrd_tvalid, 0);

        // Capture after reset
        do_capture(7, 2, 5, 4'b1100, 0, 1, 0, 1);
        wait_done();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
